// File: rtl/uart_rx_oversampled.sv
// UART receiver with 16x oversampling: recovers LSB-first frames (start, DBIT data, optional
// parity, stop) and reports each word with a 1-cycle done strobe plus frame/parity error flags.
module uart_rx_oversampled #(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned SB_TICK    = 16,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    // s must reach 15 for data/parity bits and SB_TICK-1 for the stop bit
    localparam int unsigned SMax = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int unsigned SW   = $clog2(SMax);
    localparam int unsigned NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e state_q, state_d;

    logic            rx_meta_q, rx_s_q;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            p_q, p_d;
    logic            armed_q, armed_d;
    logic [DBIT-1:0] dout_q;
    logic            done_q, frame_err_q, parity_err_q;

    logic s_mid, s_end, s_stop, last_bit, start_seen;
    logic clr_s, inc_s, clr_n, inc_n, shift, cap_p, frame_done;

    assign s_mid      = s_tick && (s_q == SW'(7));
    assign s_end      = s_tick && (s_q == SW'(15));
    assign s_stop     = s_tick && (s_q == SW'(SB_TICK - 1));
    assign last_bit   = (n_q == NW'(DBIT - 1));
    assign start_seen = armed_q && !rx_s_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_seen) state_d = StStart;
            end
            StStart: begin
                // A line back high at mid start bit is a glitch, not a frame
                if (s_mid) state_d = rx_s_q ? StIdle : StData;
            end
            StData: begin
                if (s_end && last_bit) state_d = PARITY_EN ? StParity : StStop;
            end
            StParity: begin
                if (s_end) state_d = StStop;
            end
            StStop: begin
                if (s_stop) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control outputs decoded from the current state
    always_comb begin
        clr_s      = 1'b0;
        inc_s      = 1'b0;
        clr_n      = 1'b0;
        inc_n      = 1'b0;
        shift      = 1'b0;
        cap_p      = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                clr_s = start_seen;
            end
            StStart: begin
                if (s_mid) begin
                    clr_s = 1'b1;
                    clr_n = 1'b1;
                end else begin
                    inc_s = s_tick;
                end
            end
            StData: begin
                if (s_end) begin
                    clr_s = 1'b1;
                    shift = 1'b1;
                    inc_n = !last_bit;
                end else begin
                    inc_s = s_tick;
                end
            end
            StParity: begin
                if (s_end) begin
                    clr_s = 1'b1;
                    cap_p = 1'b1;
                end else begin
                    inc_s = s_tick;
                end
            end
            StStop: begin
                if (s_stop) begin
                    clr_s      = 1'b1;
                    frame_done = 1'b1;
                end else begin
                    inc_s = s_tick;
                end
            end
            default: begin
                clr_s = 1'b1;
            end
        endcase
    end

    // Datapath next-state
    always_comb begin
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        p_d     = p_q;
        armed_d = armed_q;
        if (clr_s) begin
            s_d = '0;
        end else if (inc_s) begin
            s_d = s_q + SW'(1);
        end
        if (clr_n) begin
            n_d = '0;
        end else if (inc_n) begin
            n_d = n_q + NW'(1);
        end
        if (shift) b_d = {rx_s_q, b_q[DBIT-1:1]};
        if (cap_p) p_d = rx_s_q;
        // Disarm after every frame so a held-low line (break) cannot start a new one
        if (frame_done) begin
            armed_d = 1'b0;
        end else if (rx_s_q) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            s_q          <= '0;
            n_q          <= '0;
            b_q          <= '0;
            p_q          <= 1'b0;
            armed_q      <= 1'b1;
            dout_q       <= '0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            s_q       <= s_d;
            n_q       <= n_d;
            b_q       <= b_d;
            p_q       <= p_d;
            armed_q   <= armed_d;
            done_q    <= frame_done;
            if (frame_done) begin
                dout_q       <= b_q;
                frame_err_q  <= ~rx_s_q;
                parity_err_q <= PARITY_EN && ((^b_q) ^ p_q ^ PARITY_ODD);
            end
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = frame_err_q;
    assign parity_err   = parity_err_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: an 8N1 and an 8E1 receiver fed from a mod-4 tick generator,
// with expected words queued at send time and checked by per-receiver strobe monitors.
module tb_uart_rx_oversampled;

    localparam int BitClk = 64;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] tick_cnt = 2'd0;
    logic       s_tick;
    logic       rx_n = 1'b1;
    logic       rx_p = 1'b1;
    logic [7:0] dout_n, dout_p;
    logic       done_n, done_p, fe_n, fe_p, pe_n, pe_p;

    int   tests = 0;
    int   failed = 0;
    int   strobes_n = 0;
    int   strobes_p = 0;
    logic prev_done_n = 1'b0;
    logic prev_done_p = 1'b0;
    exp_t q_n[$];
    exp_t q_p[$];
    exp_t e_n, e_p;

    always #5 clk = ~clk;

    always @(posedge clk) tick_cnt <= tick_cnt + 2'd1;
    assign s_tick = (tick_cnt == 2'd3);

    uart_rx_oversampled #(
        .DBIT(8), .SB_TICK(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
    ) dut_n (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_n),
        .dout(dout_n), .rx_done_tick(done_n), .frame_err(fe_n), .parity_err(pe_n)
    );

    uart_rx_oversampled #(
        .DBIT(8), .SB_TICK(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
    ) dut_p (
        .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_p),
        .dout(dout_p), .rx_done_tick(done_p), .frame_err(fe_p), .parity_err(pe_p)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Even parity: the data ones plus the parity bit must total an even count
    function automatic logic model_pe(input logic [7:0] d, input bit pbit);
        return ((($countones(d) + int'(pbit)) % 2) != 0);
    endfunction

    always @(negedge clk) begin
        if (done_n) begin
            check("n_no_back_to_back_strobe", {31'd0, prev_done_n}, 32'd0);
            strobes_n++;
            if (q_n.size() == 0) begin
                check("n_unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e_n = q_n.pop_front();
                check("n_dout", {24'd0, dout_n}, {24'd0, e_n.d});
                check("n_frame_err", {31'd0, fe_n}, {31'd0, e_n.fe});
                check("n_parity_err", {31'd0, pe_n}, {31'd0, e_n.pe});
            end
        end
        prev_done_n <= done_n;
    end

    always @(negedge clk) begin
        if (done_p) begin
            check("p_no_back_to_back_strobe", {31'd0, prev_done_p}, 32'd0);
            strobes_p++;
            if (q_p.size() == 0) begin
                check("p_unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e_p = q_p.pop_front();
                check("p_dout", {24'd0, dout_p}, {24'd0, e_p.d});
                check("p_frame_err", {31'd0, fe_p}, {31'd0, e_p.fe});
                check("p_parity_err", {31'd0, pe_p}, {31'd0, e_p.pe});
            end
        end
        prev_done_p <= done_p;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rx(input bit to_p, input logic v);
        if (to_p) rx_p = v;
        else rx_n = v;
    endtask

    task automatic check_reset_outputs();
        check("rst_dout_n", {24'd0, dout_n}, 32'd0);
        check("rst_done_n", {31'd0, done_n}, 32'd0);
        check("rst_frame_err_n", {31'd0, fe_n}, 32'd0);
        check("rst_parity_err_n", {31'd0, pe_n}, 32'd0);
        check("rst_dout_p", {24'd0, dout_p}, 32'd0);
        check("rst_done_p", {31'd0, done_p}, 32'd0);
    endtask

    // Drives one frame; abort_pos >= 0 pulses reset mid-way through that bit position
    // (0 = start bit, 1..8 = data bits) and abandons the frame with the line released high.
    task automatic send_frame(input bit to_p, input logic [7:0] data, input bit pbit,
                              input bit stop_bit, input int abort_pos);
        logic bits[$];
        exp_t e;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (to_p) bits.push_back(pbit);
        bits.push_back(stop_bit);
        if (abort_pos < 0) begin
            e.d  = data;
            e.fe = !stop_bit;
            e.pe = to_p ? model_pe(data, pbit) : 1'b0;
            if (to_p) q_p.push_back(e);
            else q_n.push_back(e);
        end
        for (int pos = 0; pos < bits.size(); pos++) begin
            set_rx(to_p, bits[pos]);
            for (int c = 0; c < BitClk; c++) begin
                if (pos == abort_pos && c == BitClk / 2) begin
                    reset = 1'b1;
                    set_rx(to_p, 1'b1);
                    @(negedge clk);
                    reset = 1'b0;
                    check_reset_outputs();
                    return;
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int         s0;
        int         gap;
        logic [7:0] d;
        bit         pb, sb;

        repeat (4) @(negedge clk);
        check_reset_outputs();
        check("rst_frame_err_p", {31'd0, fe_p}, 32'd0);
        check("rst_parity_err_p", {31'd0, pe_p}, 32'd0);
        reset = 1'b0;
        idle(2 * BitClk);

        // Clean 8N1 frame
        s0 = strobes_n;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, -1);
        idle(BitClk);
        check("a5_strobe_count", 32'(strobes_n - s0), 32'd1);

        // Start-bit glitch of 4 s_ticks
        s0 = strobes_n;
        rx_n = 1'b0;
        idle(16);
        rx_n = 1'b1;
        idle(4 * BitClk);
        check("glitch_strobe_count", 32'(strobes_n - s0), 32'd0);
        check("glitch_dout_held", {24'd0, dout_n}, 32'h0000_00A5);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b1, -1);
        idle(BitClk);

        // Bad stop bit followed by a held-low break
        s0 = strobes_n;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, -1);
        idle(20 * BitClk);
        check("break_strobe_count", 32'(strobes_n - s0), 32'd1);
        rx_n = 1'b1;
        idle(2 * BitClk);
        check("break_release_strobe_count", 32'(strobes_n - s0), 32'd1);

        // Even parity, correct then wrong parity bit
        s0 = strobes_p;
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, -1);
        idle(BitClk);
        send_frame(1'b1, 8'h07, 1'b0, 1'b1, -1);
        idle(BitClk);
        check("parity_strobe_count", 32'(strobes_p - s0), 32'd2);

        // Reset during data bit 3, then a fresh frame
        s0 = strobes_n;
        send_frame(1'b0, 8'h81, 1'b0, 1'b1, 4);
        idle(3 * BitClk);
        check("reset_abort_strobe_count", 32'(strobes_n - s0), 32'd0);
        send_frame(1'b0, 8'h55, 1'b0, 1'b1, -1);
        idle(BitClk);

        // Back-to-back frames with no idle gap
        s0 = strobes_n;
        send_frame(1'b0, 8'h00, 1'b0, 1'b1, -1);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b1, -1);
        idle(BitClk);
        check("b2b_strobe_count", 32'(strobes_n - s0), 32'd2);

        // Random traffic on both receivers
        for (int i = 0; i < 12; i++) begin
            d   = 8'($urandom);
            sb  = ($urandom_range(0, 3) != 0);
            gap = sb ? $urandom_range(0, 80) : BitClk + $urandom_range(0, 80);
            send_frame(1'b0, d, 1'b0, sb, -1);
            rx_n = 1'b1;
            idle(gap);
        end
        for (int i = 0; i < 12; i++) begin
            d   = 8'($urandom);
            pb  = 1'($urandom);
            gap = $urandom_range(0, 80);
            send_frame(1'b1, d, pb, 1'b1, -1);
            idle(gap);
        end

        idle(2 * BitClk);
        check("n_queue_drained", 32'(q_n.size()), 32'd0);
        check("p_queue_drained", 32'(q_p.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
